reply_matcher_noc2node: RTL
===========================

# reply_matcher_noc2node

Return-path stage facing the pending-transaction table of the node-to-NoC direction. Accepts reply packets arriving from the NoC flit by flit and registers each head flit. It looks the transaction up in the pending table (combinational query/delete port), retires the matching entry and forwards the whole packet toward the local WISHBONE masters. Replies with no pending entry are dropped and counted.

## Interface
- N_BIT_FLIT, 32: flit width; must be ≥ `N_BIT_CMD_HEAD_FLIT+`N_BIT_SRC_HEAD_FLIT+`N_BIT_DEST_HEAD_FLIT.
- N_BITS_ORPHAN_CNT, 8: width of saturating orphan-reply counter.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_flit_valid_i  in  1  NoC flit valid.
- in_flit_i  in  N_BIT_FLIT  flit; head layout: [C-1:0] cmd, [C+S-1:C] src, [C+S+D-1:C+S] dest (C/S/D = cmd/src/dest define widths).
- in_is_head_i / in_is_tail_i  in  1 each  flit position flags; both high = single-flit packet.
- in_flit_ready_o  out  1  flit consumed when valid&ready.
- query_o  out  1  table query strobe.
- query_sender_o  out  `N_BIT_SRC_HEAD_FLIT  = head dest field (local master that issued the request).
- query_recipient_o  out  `N_BIT_DEST_HEAD_FLIT  = head src field (remote node replying).
- query_transaction_type_o  out  `N_BIT_CMD_HEAD_FLIT  = head cmd field.
- delete_transaction_o  out  1  retire the queried entry at end of cycle.
- is_a_pending_transaction_i  in  1  table reply, combinational, same cycle as query_o.
- out_valid_o / out_ready_i  out/in  1 each  output handshake toward the WISHBONE master side.
- out_flit_o  out  N_BIT_FLIT  forwarded flit; out_is_head_o, out_is_tail_o  out  1 each.
- orphan_reply_o  out  1  one-cycle pulse per dropped packet.
- protocol_error_o  out  1  one-cycle pulse per stray body/tail flit consumed in IDLE.
- orphan_count_o  out  N_BITS_ORPHAN_CNT  saturating orphan count.

## Operation
- States: IDLE, LOOKUP, SEND_HEAD, FORWARD, DROP.
- IDLE: in_flit_ready_o=1. Head accepted → head_r, head_tail_r=in_is_tail_i, go LOOKUP. Non-head flit accepted → discarded, protocol_error_o pulse next cycle, stay IDLE.
- LOOKUP: in_flit_ready_o=0; query_o=1, fields driven from head_r. Match → delete_transaction_o=1 in that same cycle, go SEND_HEAD. Miss → delete_transaction_o=0, orphan_reply_o pulse next cycle, count+1 (saturate at all-ones); go IDLE if head_tail_r else DROP.
- SEND_HEAD: out_valid_o=1, out_flit_o=head_r, out_is_head_o=1, out_is_tail_o=head_tail_r, in_flit_ready_o=0. On out_ready_i: go IDLE if head_tail_r else FORWARD.
- FORWARD: combinational pass-through: out_valid_o=in_flit_valid_i, in_flit_ready_o=out_ready_i, out_flit_o=in_flit_i, out_is_tail_o=in_is_tail_i, out_is_head_o=0. Tail handshake → IDLE. A head flag seen mid-packet is treated as body (flag not forwarded).
- DROP: in_flit_ready_o=1, out_valid_o=0; tail accepted → IDLE.
- query_o and delete_transaction_o are never high outside LOOKUP. Exactly one table query per packet.

## Timing
- Reset: state IDLE; out_valid_o, query_o, delete_transaction_o, orphan_reply_o, protocol_error_o = 0; orphan_count_o=0; in_flit_ready_o=1 from the first cycle after reset.
- Head accepted at cycle N → query/delete at N+1 → out head valid earliest N+2. Body flits: 0-cycle latency, 1 flit/cycle.
- Minimum inter-packet gap on input: 2 cycles (LOOKUP + SEND_HEAD) for a matched packet, 1 for an orphan.
- Table insert in the same cycle as delete is legal and handled by the table.
- Reset mid-packet: state lost. Later flits of that packet arrive in IDLE as non-head flits and each raises protocol_error_o.
- out_ready_i low holds SEND_HEAD/FORWARD indefinitely. out_flit_o stays stable while out_valid_o&!out_ready_i.

## Test plan
- Pending entry (sender 2, recipient 5, cmd 1); send 3-flit reply dest=2, src=5, cmd=1 → query at N+1 with delete=1, head out at N+2, body at 1/cycle, tail ends packet, state IDLE.
- Same reply with no table entry → delete=0, orphan_reply_o pulses once, orphan_count_o 0→1, all 3 flits consumed, out_valid_o never high.
- Single-flit matched reply (head&tail) → one output beat with out_is_head_o=out_is_tail_o=1, back to IDLE, next head accepted the following cycle.
- out_ready_i held low 4 cycles in SEND_HEAD and mid-FORWARD → in_flit_ready_o low, out_flit_o stable, no flit lost or duplicated.
- 260 orphan packets → orphan_count_o saturates at 255.
- Body flit in IDLE → consumed, protocol_error_o one pulse. rst asserted mid-FORWARD → all outputs reach reset values next cycle, and the remaining flits raise protocol_error_o.

Source files
------------

// File: rtl/reply_matcher_noc2node.sv
// Reply matcher: looks each NoC reply head up in the pending-transaction table,
// retires the matching entry and forwards the packet; unmatched replies are dropped.
`ifndef N_BIT_CMD_HEAD_FLIT
`define N_BIT_CMD_HEAD_FLIT 4
`endif
`ifndef N_BIT_SRC_HEAD_FLIT
`define N_BIT_SRC_HEAD_FLIT 4
`endif
`ifndef N_BIT_DEST_HEAD_FLIT
`define N_BIT_DEST_HEAD_FLIT 4
`endif

module reply_matcher_noc2node #(
  parameter int N_BIT_FLIT        = 32,
  parameter int N_BITS_ORPHAN_CNT = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_flit_valid_i,
  input  logic [N_BIT_FLIT-1:0]            in_flit_i,
  input  logic                             in_is_head_i,
  input  logic                             in_is_tail_i,
  output logic                             in_flit_ready_o,
  output logic                             query_o,
  output logic [`N_BIT_SRC_HEAD_FLIT-1:0]  query_sender_o,
  output logic [`N_BIT_DEST_HEAD_FLIT-1:0] query_recipient_o,
  output logic [`N_BIT_CMD_HEAD_FLIT-1:0]  query_transaction_type_o,
  output logic                             delete_transaction_o,
  input  logic                             is_a_pending_transaction_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [N_BIT_FLIT-1:0]            out_flit_o,
  output logic                             out_is_head_o,
  output logic                             out_is_tail_o,
  output logic                             orphan_reply_o,
  output logic                             protocol_error_o,
  output logic [N_BITS_ORPHAN_CNT-1:0]     orphan_count_o
);

  localparam int C = `N_BIT_CMD_HEAD_FLIT;
  localparam int S = `N_BIT_SRC_HEAD_FLIT;
  localparam int D = `N_BIT_DEST_HEAD_FLIT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_SEND_HEAD,
    S_FORWARD,
    S_DROP
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [N_BIT_FLIT-1:0]        r_head;
  logic                         r_head_tail;
  logic                         r_orphan;
  logic                         r_proto_err;
  logic [N_BITS_ORPHAN_CNT-1:0] r_orphan_cnt;
  logic                         w_idle_head;
  logic                         w_idle_stray;
  logic                         w_miss;

  // Input is always ready in IDLE, so valid alone qualifies an accepted flit there.
  assign w_idle_head  = (r_state == S_IDLE) && in_flit_valid_i && in_is_head_i;
  assign w_idle_stray = (r_state == S_IDLE) && in_flit_valid_i && !in_is_head_i;
  assign w_miss       = (r_state == S_LOOKUP) && !is_a_pending_transaction_i;

  // The reply travels back, so its dest is our local sender and its src the remote recipient.
  assign query_transaction_type_o = r_head[C-1:0];
  assign query_recipient_o        = r_head[C+S-1:C];
  assign query_sender_o           = r_head[C+S+D-1:C+S];

  assign orphan_reply_o   = r_orphan;
  assign protocol_error_o = r_proto_err;
  assign orphan_count_o   = r_orphan_cnt;

  always_comb begin
    w_state_nxt          = r_state;
    in_flit_ready_o      = 1'b0;
    query_o              = 1'b0;
    delete_transaction_o = 1'b0;
    out_valid_o          = 1'b0;
    out_flit_o           = r_head;
    out_is_head_o        = 1'b0;
    out_is_tail_o        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_flit_ready_o = 1'b1;
        if (in_flit_valid_i && in_is_head_i) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        query_o              = 1'b1;
        delete_transaction_o = is_a_pending_transaction_i;
        if (is_a_pending_transaction_i) w_state_nxt = S_SEND_HEAD;
        else if (r_head_tail)           w_state_nxt = S_IDLE;
        else                            w_state_nxt = S_DROP;
      end
      S_SEND_HEAD: begin
        out_valid_o   = 1'b1;
        out_is_head_o = 1'b1;
        out_is_tail_o = r_head_tail;
        if (out_ready_i) w_state_nxt = r_head_tail ? S_IDLE : S_FORWARD;
      end
      S_FORWARD: begin
        out_valid_o     = in_flit_valid_i;
        in_flit_ready_o = out_ready_i;
        out_flit_o      = in_flit_i;
        out_is_tail_o   = in_is_tail_i;
        if (in_flit_valid_i && out_ready_i && in_is_tail_i) w_state_nxt = S_IDLE;
      end
      S_DROP: begin
        in_flit_ready_o = 1'b1;
        if (in_flit_valid_i && in_is_tail_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_head       <= '0;
      r_head_tail  <= 1'b0;
      r_orphan     <= 1'b0;
      r_proto_err  <= 1'b0;
      r_orphan_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_orphan    <= w_miss;
      r_proto_err <= w_idle_stray;
      if (w_idle_head) begin
        r_head      <= in_flit_i;
        r_head_tail <= in_is_tail_i;
      end
      if (w_miss && (r_orphan_cnt != '1)) r_orphan_cnt <= r_orphan_cnt + 1'b1;
    end
  end

endmodule
